// File: rtl/mac_operand_feeder.sv
// rtl/mac_operand_feeder.sv - operand burst buffer feeding a mac lane's Ain/En inputs
module mac_operand_feeder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       wren,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       start,
    output logic [WIDTH-1:0]           dout,
    output logic                       en_out,
    output logic                       done,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAINED
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              push;
    logic              pop;
    logic              fin;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [WIDTH-1:0]  mem [DEPTH];

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

    // start outranks wren in IDLE; the last pop (count 1->0) hands over to DRAINED
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        pop       = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE: begin
                if (start && !empty) begin
                    pop       = 1'b1;
                    state_nxt = (count == CNT_ONE) ? DRAINED : STREAM;
                end else if (wren && !full) begin
                    push = 1'b1;
                end
            end
            STREAM: begin
                pop = 1'b1;
                if (count == CNT_ONE) begin
                    state_nxt = DRAINED;
                end
            end
            DRAINED: begin
                fin       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            dout   <= '0;
            en_out <= 1'b0;
            done   <= 1'b0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            dout   <= '0;
            en_out <= 1'b0;
            done   <= 1'b0;
        end else begin
            en_out <= pop;
            done   <= fin;
            if (pop) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PTR_ONE;
                count  <= count - CNT_ONE;
            end else if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                count  <= count + CNT_ONE;
            end
        end
    end

    // storage needs no reset; only entries below count are ever read
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// tb/tb_mac_operand_feeder.sv - directed and random checks of mac_operand_feeder against a queue model
module tb_mac_operand_feeder;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr;
    logic             wren;
    logic [WIDTH-1:0] wdata;
    logic             start;
    logic [WIDTH-1:0] dout;
    logic             en_out;
    logic             done;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] held_q[$];
    logic [WIDTH-1:0] out_q[$];
    bit               done_pend;
    logic [WIDTH-1:0] exp_dout;
    bit               exp_en;
    bit               exp_done;

    mac_operand_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .wren   (wren),
        .wdata  (wdata),
        .start  (start),
        .dout   (dout),
        .en_out (en_out),
        .done   (done),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        held_q    = {};
        out_q     = {};
        done_pend = 1'b0;
        exp_dout  = '0;
        exp_en    = 1'b0;
        exp_done  = 1'b0;
    endfunction

    function automatic void model_pop();
        exp_dout = out_q.pop_front();
        exp_en   = 1'b1;
        exp_done = 1'b0;
        if (out_q.size() == 0) done_pend = 1'b1;
    endfunction

    function automatic void model_edge(input bit c, input bit w, input logic [WIDTH-1:0] d, input bit s);
        if (c) begin
            model_reset();
        end else if (out_q.size() > 0) begin
            model_pop();
        end else if (done_pend) begin
            exp_en    = 1'b0;
            exp_done  = 1'b1;
            done_pend = 1'b0;
        end else begin
            exp_en   = 1'b0;
            exp_done = 1'b0;
            if (s && held_q.size() > 0) begin
                out_q  = held_q;
                held_q = {};
                model_pop();
            end else if (w && held_q.size() < DEPTH) begin
                held_q.push_back(d);
            end
        end
    endfunction

    task automatic check(input string tag);
        int n;
        n = held_q.size() + out_q.size();
        total++;
        assert (dout === exp_dout) else begin
            bad++; $error("FAIL %s dout got=%0h exp=%0h", tag, dout, exp_dout);
        end
        total++;
        assert (en_out === exp_en) else begin
            bad++; $error("FAIL %s en_out got=%0b exp=%0b", tag, en_out, exp_en);
        end
        total++;
        assert (done === exp_done) else begin
            bad++; $error("FAIL %s done got=%0b exp=%0b", tag, done, exp_done);
        end
        total++;
        assert (count === CW'(n)) else begin
            bad++; $error("FAIL %s count got=%0d exp=%0d", tag, count, n);
        end
        total++;
        assert (full === (n == DEPTH)) else begin
            bad++; $error("FAIL %s full got=%0b exp=%0b", tag, full, (n == DEPTH));
        end
        total++;
        assert (empty === (n == 0)) else begin
            bad++; $error("FAIL %s empty got=%0b exp=%0b", tag, empty, (n == 0));
        end
    endtask

    task automatic step(input string tag, input bit c, input bit w, input logic [WIDTH-1:0] d, input bit s);
        clr   = c;
        wren  = w;
        wdata = d;
        start = s;
        @(posedge clk);
        model_edge(c, w, d, s);
        #1;
        check(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic write_rand(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b1, WIDTH'($urandom), 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        wren  = 1'b0;
        wdata = '0;
        start = 1'b0;
        model_reset();
        #12;
        check("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // burst of three, fixed values
        step("w3", 1'b0, 1'b1, 8'd3, 1'b0);
        step("w5", 1'b0, 1'b1, 8'd5, 1'b0);
        step("w7", 1'b0, 1'b1, 8'd7, 1'b0);
        step("start3", 1'b0, 1'b0, '0, 1'b1);
        idle("stream3", 4);

        // fill, overflow attempt, drain
        write_rand("fill", DEPTH);
        step("overflow", 1'b0, 1'b1, 8'hee, 1'b0);
        step("start8", 1'b0, 1'b0, '0, 1'b1);
        idle("stream8", DEPTH + 2);

        // pointer wrap across two bursts
        write_rand("wrap_a", 6);
        step("start6", 1'b0, 1'b0, '0, 1'b1);
        idle("stream6", 7);
        write_rand("wrap_b", 5);
        step("start5", 1'b0, 1'b0, '0, 1'b1);
        idle("stream5", 6);

        // start on empty, then start colliding with a write
        step("start_empty", 1'b0, 1'b0, '0, 1'b1);
        idle("empty_idle", 2);
        write_rand("two", 2);
        step("start_wren", 1'b0, 1'b1, 8'h99, 1'b1);
        idle("stream2", 3);

        // clear during the second stream cycle
        write_rand("four", 4);
        step("start4", 1'b0, 1'b0, '0, 1'b1);
        step("clr", 1'b1, 1'b0, '0, 1'b0);
        idle("after_clr", 3);
        write_rand("fresh", 3);
        step("start_fresh", 1'b0, 1'b0, '0, 1'b1);
        idle("stream_fresh", 4);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0),
                 WIDTH'($urandom), ($urandom_range(0, 5) == 0));
        end
        idle("rand_tail", DEPTH + 2);

        // asynchronous reset in the middle of a stream
        write_rand("pre_rst", 4);
        step("start_rst", 1'b0, 1'b0, '0, 1'b1);
        step("mid_stream", 1'b0, 1'b0, '0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst");
        @(posedge clk);
        #1;
        check("rst_hold");
        rst_n = 1'b1;
        idle("post_rst", 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
